dmem_arbiter: RTL and testbench

- Shares the single-port 16-word data memory between two requesters: port 0 is the core load/store path, port 1 is the debug/loader path.
- Each request is sequenced through a 3-state FSM. The block drives the memory's address, write-data and write-enable, and returns a registered read result.
- It sits between the requesters and the data memory. The memory's combinational read output feeds back into this block.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arbiter_if.sv | 30 +++
 rtl/dmem_arbiter_rr_arb2.sv | 21 ++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEPTH_DEFAULT = 16;
  localparam int DATA_W        = 32;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT_DBG) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bus of dmem_arbiter; slave = arbiter, master = requesters plus memory.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic [1:0]        req;
  logic [1:0]        we;
  logic [DATA_W-1:0] addr0;
  logic [DATA_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt, done, rdata, err, mem_addr, mem_wdata, mem_wen
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt, done, rdata, err, mem_addr, mem_wdata, mem_wen
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational 2-way winner select: round-robin on ties, or port 0 always wins
// ties when DMEM_ARB_FIXED_PRIO_EN is defined. Zero latency, no backpressure.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic       winner,
  output logic       any
);

  assign any = |req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused_last_winner;
  assign unused_last_winner = last_winner;
  assign winner = ~req[0];
`else
  // On a tie the port that did not win last time goes next.
  assign winner = (&req) ? ~last_winner : req[1];
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between core (port 0) and debug (port 1); gnt at N+1,
// done at N+2, one access per 3 cycles; losers keep req held. DMEM_ARB_FIXED_PRIO_EN selects fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  arb_state_t state, state_nxt;

  logic              win;
  logic              any_req;
  logic              last_winner;
  logic              latch;
  logic              finish;

  logic              win_q;
  logic              we_q;
  logic              in_range_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  rr_arb2 u_arb (
    .req         (bus.req),
    .last_winner (last_winner),
    .winner      (win),
    .any         (any_req)
  );

  assign sel_addr  = win ? bus.addr1  : bus.addr0;
  assign sel_wdata = win ? bus.wdata1 : bus.wdata0;
  assign sel_we    = bus.we[win];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    latch         = 1'b0;
    finish        = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wen   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          latch     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        finish        = 1'b1;
        bus.mem_addr  = {{(DATA_W-ADDR_W){1'b0}}, addr_q};
        bus.mem_wdata = wdata_q;
        // Gating with rst keeps a write from committing on the reset edge.
        bus.mem_wen   = we_q & in_range_q & ~rst;
        state_nxt     = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.gnt     <= '0;
      bus.done    <= '0;
      bus.rdata   <= '0;
      bus.err     <= 1'b0;
      last_winner <= PORT_DBG;
      win_q       <= PORT_CORE;
      we_q        <= 1'b0;
      in_range_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      bus.gnt  <= latch  ? port_onehot(win)   : 2'b00;
      bus.done <= finish ? port_onehot(win_q) : 2'b00;
      if (latch) begin
        win_q      <= win;
        we_q       <= sel_we;
        in_range_q <= (sel_addr < DATA_W'(DEPTH));
        addr_q     <= sel_addr[ADDR_W-1:0];
        wdata_q    <= sel_wdata;
      end
      if (finish) begin
        last_winner <= win_q;
        bus.err     <= ~in_range_q;
        if (!in_range_q)  bus.rdata <= '0;
        else if (!we_q)   bus.rdata <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter against a memory-array reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single-port memory: combinational read, write on the rising edge.
  logic [31:0] mem [16] = '{default: 32'h0};
  assign bus.mem_rdata = mem[bus.mem_addr[3:0]];
  always @(posedge clk) if (bus.mem_wen) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  int          last_win;
  logic [31:0] rdata_exp;
  logic        err_exp;

  bit          pend  [2];
  logic        c_we  [2];
  logic [31:0] c_addr[2];
  logic [31:0] c_wd  [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req    = {pend[1], pend[0]};
    bus.we     = {c_we[1], c_we[0]};
    bus.addr0  = c_addr[0];
    bus.addr1  = c_addr[1];
    bus.wdata0 = c_wd[0];
    bus.wdata1 = c_wd[1];
  endtask

  task automatic set_cmd(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    pend[p]   = 1'b1;
    c_we[p]   = w;
    c_addr[p] = a;
    c_wd[p]   = d;
  endtask

  function automatic int pick();
    if (pend[0] && pend[1]) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (last_win == 0) ? 1 : 0;
`endif
    end
    return pend[0] ? 0 : 1;
  endfunction

  // One arbitration from IDLE; rearm keeps the winner requesting the same command.
  task automatic run_txn(input bit rearm, output logic [1:0] g);
    int          w;
    logic [31:0] a;
    bit          inr;
    drive();
    chk("gnt_idle", {30'b0, bus.gnt}, 32'h0);
    w   = pick();
    a   = c_addr[w];
    inr = (a < 32'd16);
    tick();
    g = bus.gnt;
    chk("gnt", {30'b0, bus.gnt}, (w == 1) ? 32'h2 : 32'h1);
    chk("done_in_access", {30'b0, bus.done}, 32'h0);
    chk("wen_access", {31'b0, bus.mem_wen}, {31'b0, c_we[w] & inr});
    chk("mem_addr", bus.mem_addr, {28'b0, a[3:0]});
    if (c_we[w] && inr) chk("mem_wdata", bus.mem_wdata, c_wd[w]);
    last_win = w;
    err_exp  = !inr;
    if (!inr)          rdata_exp = 32'h0;
    else if (c_we[w])  ref_mem[a[3:0]] = c_wd[w];
    else               rdata_exp = ref_mem[a[3:0]];
    if (!rearm) begin
      pend[w] = 1'b0;
      drive();
    end
    tick();
    chk("done", {30'b0, bus.done}, (w == 1) ? 32'h2 : 32'h1);
    chk("gnt_in_resp", {30'b0, bus.gnt}, 32'h0);
    chk("err", {31'b0, bus.err}, {31'b0, err_exp});
    chk("rdata", bus.rdata, rdata_exp);
    chk("wen_resp", {31'b0, bus.mem_wen}, 32'h0);
    tick();
  endtask

  task automatic check_reset_outputs();
    chk("rst_gnt", {30'b0, bus.gnt}, 32'h0);
    chk("rst_done", {30'b0, bus.done}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_err", {31'b0, bus.err}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_wen", {31'b0, bus.mem_wen}, 32'h0);
  endtask

  logic [1:0] g;
  logic [1:0] rr_tbl [4];

  initial begin
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; c_we[p] = 1'b0; c_addr[p] = '0; c_wd[p] = '0;
    end
    drive();
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs();
    rst = 1'b0;
    last_win = 1; rdata_exp = 32'h0; err_exp = 1'b0;

    // Core write then debug read-back of the same word.
    set_cmd(0, 1'b1, 32'd3, 32'hDEADBEEF);
    run_txn(1'b0, g);
    set_cmd(1, 1'b0, 32'd3, 32'h0);
    run_txn(1'b0, g);
    chk("readback_deadbeef", bus.rdata, 32'hDEADBEEF);

    // Both ports requesting continuously.
`ifdef DMEM_ARB_FIXED_PRIO_EN
    rr_tbl = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    rr_tbl = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    set_cmd(0, 1'b0, 32'd3, 32'h0);
    set_cmd(1, 1'b0, 32'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, g);
      chk("tie_sequence", {30'b0, g}, {30'b0, rr_tbl[i]});
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive();
    tick();

    // Out-of-range write must not alias onto word 0.
    set_cmd(1, 1'b1, 32'd16, 32'h1234);
    run_txn(1'b0, g);
    chk("oor_write_err", {31'b0, bus.err}, 32'h1);
    set_cmd(0, 1'b0, 32'd0, 32'h0);
    run_txn(1'b0, g);
    chk("addr0_untouched", bus.rdata, 32'h0);

    // Out-of-range read with high address bits set.
    set_cmd(0, 1'b0, 32'hFFFF_FFF5, 32'h0);
    run_txn(1'b0, g);
    chk("oor_read_rdata", bus.rdata, 32'h0);

    // Reset landing on the ACCESS cycle of a write.
    set_cmd(0, 1'b1, 32'd5, 32'h11);
    run_txn(1'b0, g);
    set_cmd(1, 1'b1, 32'd5, 32'h22);
    drive();
    tick();
    chk("gnt_before_rst", {30'b0, bus.gnt}, 32'h2);
    rst = 1'b1;
    #1;
    chk("wen_forced_low", {31'b0, bus.mem_wen}, 32'h0);
    pend[1] = 1'b0;
    drive();
    tick();
    check_reset_outputs();
    rst = 1'b0;
    last_win = 1; rdata_exp = 32'h0; err_exp = 1'b0;
    set_cmd(0, 1'b0, 32'd5, 32'h0);
    set_cmd(1, 1'b0, 32'd5, 32'h0);
    run_txn(1'b0, g);
    chk("post_rst_tie_port0", {30'b0, g}, 32'h1);
    chk("addr5_kept", bus.rdata, 32'h11);
    run_txn(1'b0, g);

    // Single-cycle req pulse: the task drops req as soon as gnt is seen.
    set_cmd(0, 1'b0, 32'd3, 32'h0);
    run_txn(1'b0, g);
    chk("pulse_read", bus.rdata, 32'hDEADBEEF);

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          logic [31:0] a;
          case ($urandom_range(0, 7))
            0:       a = 32'd16 + $urandom_range(0, 100);
            1:       a = $urandom() | 32'h8000_0000;
            default: a = $urandom_range(0, 15);
          endcase
          set_cmd(p, $urandom_range(0, 1) == 1, a, $urandom());
        end
      end
      if (!pend[0] && !pend[1]) begin
        drive();
        tick();
        chk("idle_gnt", {30'b0, bus.gnt}, 32'h0);
        chk("idle_wen", {31'b0, bus.mem_wen}, 32'h0);
        chk("rdata_hold", bus.rdata, rdata_exp);
      end else begin
        run_txn(1'b0, g);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
